// File: rtl/rv32i_exec_core.sv
// RV32I decode / integer ALU / branch-PC unit for a multi-cycle core.
// Operands and the instruction word are latched on decode_en, and the
// instruction is executed from those latched copies on execute_en.
module rv32i_exec_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        decode_en,
  input  logic        execute_en,
  input  logic [31:0] instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [31:0] op3,
  output logic [4:0]  rd,
  output logic [31:0] pc,
  output logic [31:0] alu_result,
  output logic        alu_valid,
  output logic [31:0] ret_addr,
  output logic [31:0] result,
  output logic        halted
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [XLEN-1:0] EBREAK = 32'h0010_0073;

  // Decode-side signals
  logic [6:0]      opc;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] d_op1, d_op2, d_op3;
  logic [RW-1:0]   d_rd;

  // Execute-side signals (from the latched instruction)
  logic [XLEN-1:0] instr_q;
  logic [6:0]      opc_q;
  logic [2:0]      f3_q;
  logic            alt_q;
  logic [RW-1:0]   shamt;
  logic            is_alu;
  logic            is_link;
  logic            br_taken;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign halted   = execute_en && (instr == EBREAK);

  assign opc   = instr[6:0];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Operand and destination selection for the instruction being decoded
  always_comb begin
    d_op1 = '0;
    d_op2 = '0;
    d_op3 = '0;
    d_rd  = '0;
    unique case (opc)
      OPC_OP: begin
        d_op1 = rs1_data;
        d_op2 = rs2_data;
        d_rd  = instr[11:7];
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        d_op1 = rs1_data;
        d_op2 = imm_i;
        d_rd  = instr[11:7];
      end
      OPC_STORE: begin
        d_op1 = rs1_data;
        d_op2 = rs2_data;
        d_op3 = imm_s;
      end
      OPC_BRANCH: begin
        d_op1 = rs1_data;
        d_op2 = rs2_data;
        d_op3 = imm_b;
      end
      OPC_LUI: begin
        d_op2 = imm_u;
        d_rd  = instr[11:7];
      end
      OPC_AUIPC: begin
        d_op1 = pc;
        d_op2 = imm_u;
        d_rd  = instr[11:7];
      end
      OPC_JAL: begin
        d_op1 = pc;
        d_op3 = imm_j;
        d_rd  = instr[11:7];
      end
      default: ;
    endcase
  end

  assign opc_q   = instr_q[6:0];
  assign f3_q    = instr_q[14:12];
  assign alt_q   = instr_q[30];
  assign shamt   = op2[4:0];
  assign is_alu  = (opc_q == OPC_OP) || (opc_q == OPC_OP_IMM) ||
                   (opc_q == OPC_LUI) || (opc_q == OPC_AUIPC);
  assign is_link = (opc_q == OPC_JAL) || (opc_q == OPC_JALR);
  assign pc_plus4 = pc + XLEN'(4);

  // Integer ALU on the latched operands
  always_comb begin
    alu_out = '0;
    if ((opc_q == OPC_LUI) || (opc_q == OPC_AUIPC)) begin
      alu_out = op1 + op2;
    end else begin
      unique case (f3_q)
        3'b000:  alu_out = ((opc_q == OPC_OP) && alt_q) ? (op1 - op2) : (op1 + op2);
        3'b001:  alu_out = op1 << shamt;
        3'b010:  alu_out = {31'd0, $signed(op1) < $signed(op2)};
        3'b011:  alu_out = {31'd0, op1 < op2};
        3'b100:  alu_out = op1 ^ op2;
        3'b101:  alu_out = alt_q ? XLEN'($signed(op1) >>> shamt) : (op1 >> shamt);
        3'b110:  alu_out = op1 | op2;
        default: alu_out = op1 & op2;
      endcase
    end
  end

  // Branch condition evaluation
  always_comb begin
    br_taken = 1'b0;
    unique case (f3_q)
      3'b000:  br_taken = (op1 == op2);
      3'b001:  br_taken = (op1 != op2);
      3'b100:  br_taken = ($signed(op1) < $signed(op2));
      3'b101:  br_taken = ($signed(op1) >= $signed(op2));
      3'b110:  br_taken = (op1 < op2);
      3'b111:  br_taken = (op1 >= op2);
      default: br_taken = 1'b0;
    endcase
  end

  // Next-PC selection
  always_comb begin
    next_pc = pc_plus4;
    unique case (opc_q)
      OPC_BRANCH: next_pc = br_taken ? (pc + op3) : pc_plus4;
      OPC_JAL:    next_pc = pc + op3;
      OPC_JALR:   next_pc = (op1 + op2) & ~XLEN'(1);
      default:    next_pc = (instr_q == EBREAK) ? pc : pc_plus4;
    endcase
  end

  // Architectural state: decode latches operands, execute updates pc/results
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= '0;
      op1        <= '0;
      op2        <= '0;
      op3        <= '0;
      rd         <= '0;
      pc         <= '0;
      alu_result <= '0;
      alu_valid  <= 1'b0;
      ret_addr   <= '0;
      result     <= '0;
    end else begin
      alu_valid <= execute_en && is_alu;
      if (decode_en) begin
        instr_q <= instr;
        op1     <= d_op1;
        op2     <= d_op2;
        op3     <= d_op3;
        rd      <= d_rd;
      end
      if (execute_en) begin
        pc <= next_pc;
        if (is_alu) begin
          alu_result <= alu_out;
        end
        if (is_link) begin
          ret_addr <= pc_plus4;
        end
        result <= is_alu ? alu_out : (is_link ? pc_plus4 : '0);
      end
    end
  end

endmodule

// File: tb/tb_rv32i_exec_core.sv
// Self-checking bench for rv32i_exec_core: directed cases plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_rv32i_exec_core;

  logic        clk;
  logic        rst;
  logic        decode_en;
  logic        execute_en;
  logic [31:0] instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] op1, op2, op3;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic        alu_valid;
  logic [31:0] ret_addr;
  logic [31:0] result;
  logic        halted;

  int checks;
  int failures;

  logic [31:0] regs [32];

  // Reference model state
  logic [31:0] m_instr, m_op1, m_op2, m_op3, m_pc, m_alu, m_ret, m_result;
  logic [4:0]  m_rd;
  logic        m_valid;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBRK   = 32'h0010_0073;

  rv32i_exec_core dut (
    .clk(clk), .rst(rst), .decode_en(decode_en), .execute_en(execute_en),
    .instr(instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .op1(op1), .op2(op2), .op3(op3), .rd(rd), .pc(pc),
    .alu_result(alu_result), .alu_valid(alu_valid), .ret_addr(ret_addr),
    .result(result), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d, input logic [6:0] op);
    return {f7, s2, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d,
                                        input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], s2, s1, f3, b[4:1], b[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] d);
    logic [20:0] j;
    j = imm[20:0];
    return {j[20], j[10:1], j[11], j[19:12], d, 7'h6F};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : regs[a];
  endfunction

  function automatic logic [31:0] ref_alu(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic alt, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b[4:0];
    if (opc == 7'h37 || opc == 7'h17) return a + b;
    case (f3)
      3'd0: return (opc == 7'h33 && alt) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_instr = 0; m_op1 = 0; m_op2 = 0; m_op3 = 0; m_rd = 0;
    m_pc = 0; m_alu = 0; m_ret = 0; m_result = 0; m_valid = 0;
  endtask

  task automatic model_decode(input logic [31:0] i, input logic [31:0] p);
    logic signed [11:0] t12;
    logic signed [12:0] t13;
    logic signed [20:0] t21;
    int imm_i, imm_s, imm_b, imm_j;
    logic [31:0] a, b, imm_u;
    t12 = i[31:20];                       imm_i = t12;
    t12 = {i[31:25], i[11:7]};            imm_s = t12;
    t13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};            imm_b = t13;
    t21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};          imm_j = t21;
    imm_u = {i[31:12], 12'h000};
    a = rf(i[19:15]);
    b = rf(i[24:20]);
    m_instr = i; m_op1 = 0; m_op2 = 0; m_op3 = 0; m_rd = 0;
    case (i[6:0])
      7'h33: begin m_op1 = a; m_op2 = b; m_rd = i[11:7]; end
      7'h13, 7'h03, 7'h67: begin m_op1 = a; m_op2 = 32'(imm_i); m_rd = i[11:7]; end
      7'h23: begin m_op1 = a; m_op2 = b; m_op3 = 32'(imm_s); end
      7'h63: begin m_op1 = a; m_op2 = b; m_op3 = 32'(imm_b); end
      7'h37: begin m_op2 = imm_u; m_rd = i[11:7]; end
      7'h17: begin m_op1 = p; m_op2 = imm_u; m_rd = i[11:7]; end
      7'h6F: begin m_op1 = p; m_op3 = 32'(imm_j); m_rd = i[11:7]; end
      default: ;
    endcase
  endtask

  task automatic model_execute();
    logic [6:0]  opc;
    logic [31:0] p4, nxt;
    opc = m_instr[6:0];
    p4 = m_pc + 32'd4;
    nxt = p4;
    m_valid = 1'b0;
    m_result = 32'd0;
    case (opc)
      7'h33, 7'h13, 7'h37, 7'h17: begin
        m_alu = ref_alu(opc, m_instr[14:12], m_instr[30], m_op1, m_op2);
        m_valid = 1'b1;
        m_result = m_alu;
      end
      7'h6F: begin nxt = m_pc + m_op3; m_ret = p4; m_result = p4; end
      7'h67: begin nxt = (m_op1 + m_op2) & 32'hFFFF_FFFE; m_ret = p4; m_result = p4; end
      7'h63: if (ref_taken(m_instr[14:12], m_op1, m_op2)) nxt = m_pc + m_op3;
      default: if (m_instr == EBRK) nxt = m_pc;
    endcase
    m_pc = nxt;
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; decode_en = 1'b0; execute_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_decode(input logic [31:0] i);
    instr = i;
    decode_en = 1'b1;
    model_decode(i, m_pc);
    m_valid = 1'b0;
    tick();
    decode_en = 1'b0;
  endtask

  task automatic do_execute();
    execute_en = 1'b1;
    model_execute();
    tick();
    execute_en = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    do_reset();
    repeat (int'(target >> 2)) begin
      do_decode(NOP);
      do_execute();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({op1, op2, op3, rd, pc, alu_result, alu_valid, ret_addr, result} !== '0) begin
      failures++;
      $display("FAIL reset_state: pc=%h op1=%h op2=%h op3=%h rd=%0d alu=%h v=%b ret=%h res=%h expected all zero",
               pc, op1, op2, op3, rd, alu_result, alu_valid, ret_addr, result);
    end
  endtask

  task automatic test_addi();
    do_reset();
    do_decode(32'h0050_0093);
    checks++;
    if (op2 !== 32'd5 || rd !== 5'd1 || op1 !== 32'd0) begin
      failures++;
      $display("FAIL addi_decode: op1=%h op2=%h rd=%0d expected 0/5/1", op1, op2, rd);
    end
    checks++;
    if (alu_valid !== 1'b0) begin
      failures++;
      $display("FAIL addi_valid_early: alu_valid=%b expected 0", alu_valid);
    end
    do_execute();
    checks++;
    if (result !== 32'd5 || alu_result !== 32'd5 || pc !== 32'd4 || alu_valid !== 1'b1) begin
      failures++;
      $display("FAIL addi_exec: result=%h alu=%h pc=%h v=%b expected 5/5/4/1",
               result, alu_result, pc, alu_valid);
    end
    tick();
    checks++;
    if (alu_valid !== 1'b0 || result !== 32'd5 || pc !== 32'd4) begin
      failures++;
      $display("FAIL addi_hold: v=%b result=%h pc=%h expected 0/5/4", alu_valid, result, pc);
    end
  endtask

  task automatic test_alu_edges();
    logic [31:0] ins_t [5];
    logic [31:0] exp_t [5];
    ins_t[0] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33); exp_t[0] = 32'h7FFF_FFFF;
    ins_t[1] = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3, 7'h33); exp_t[1] = 32'h0000_0001;
    ins_t[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd3, 7'h33); exp_t[2] = 32'h0000_0000;
    ins_t[3] = enc_i(12'h404, 5'd1, 3'd5, 5'd3, 7'h13);     exp_t[3] = 32'hF800_0000;
    ins_t[4] = enc_i(12'h004, 5'd1, 3'd5, 5'd3, 7'h13);     exp_t[4] = 32'h0800_0000;
    do_reset();
    regs[1] = 32'h8000_0000;
    regs[2] = 32'd1;
    for (int k = 0; k < 5; k++) begin
      do_decode(ins_t[k]);
      do_execute();
      checks++;
      if (result !== exp_t[k] || alu_result !== exp_t[k] || rd !== 5'd3) begin
        failures++;
        $display("FAIL alu_edge[%0d]: result=%h alu=%h rd=%0d expected %h rd=3",
                 k, result, alu_result, rd, exp_t[k]);
      end
    end
  endtask

  task automatic test_branch();
    goto_pc(32'h20);
    regs[1] = 32'd7;
    regs[2] = 32'd7;
    do_decode(enc_b(-8, 5'd2, 5'd1, 3'd0));
    checks++;
    if (rd !== 5'd0 || op3 !== 32'hFFFF_FFF8) begin
      failures++;
      $display("FAIL beq_decode: rd=%0d op3=%h expected 0/fffffff8", rd, op3);
    end
    do_execute();
    checks++;
    if (pc !== 32'h18 || result !== 32'd0 || alu_valid !== 1'b0) begin
      failures++;
      $display("FAIL beq_taken: pc=%h result=%h v=%b expected 18/0/0", pc, result, alu_valid);
    end
    goto_pc(32'h20);
    regs[2] = 32'd8;
    do_decode(enc_b(-8, 5'd2, 5'd1, 3'd0));
    do_execute();
    checks++;
    if (pc !== 32'h24) begin
      failures++;
      $display("FAIL beq_not_taken: pc=%h expected 24", pc);
    end
  endtask

  task automatic test_jumps();
    goto_pc(32'h40);
    do_decode(enc_j(32'h100, 5'd1));
    do_execute();
    checks++;
    if (pc !== 32'h140 || result !== 32'h44 || ret_addr !== 32'h44 || rd !== 5'd1) begin
      failures++;
      $display("FAIL jal: pc=%h result=%h ret=%h rd=%0d expected 140/44/44/1",
               pc, result, ret_addr, rd);
    end
    regs[2] = 32'h200;
    do_decode(enc_i(12'd3, 5'd2, 3'd0, 5'd1, 7'h67));
    do_execute();
    checks++;
    if (pc !== 32'h202 || result !== 32'h144 || ret_addr !== 32'h144) begin
      failures++;
      $display("FAIL jalr: pc=%h result=%h ret=%h expected 202/144/144", pc, result, ret_addr);
    end
  endtask

  task automatic test_upper();
    do_reset();
    do_decode(32'h1234_52B7);
    do_execute();
    checks++;
    if (result !== 32'h1234_5000 || rd !== 5'd5 || alu_valid !== 1'b1) begin
      failures++;
      $display("FAIL lui: result=%h rd=%0d v=%b expected 12345000/5/1", result, rd, alu_valid);
    end
    goto_pc(32'h10);
    do_decode(32'h0000_1097);
    do_execute();
    checks++;
    if (result !== 32'h1010 || pc !== 32'h14) begin
      failures++;
      $display("FAIL auipc: result=%h pc=%h expected 1010/14", result, pc);
    end
  endtask

  task automatic test_ebreak();
    goto_pc(32'h8);
    do_decode(EBRK);
    checks++;
    if (halted !== 1'b0 || rd !== 5'd0 || op1 !== 32'd0 || op2 !== 32'd0) begin
      failures++;
      $display("FAIL ebreak_decode: halted=%b rd=%0d op1=%h op2=%h expected 0/0/0/0",
               halted, rd, op1, op2);
    end
    execute_en = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL ebreak_halted: halted=%b expected 1", halted);
    end
    execute_en = 1'b0;
    do_execute();
    checks++;
    if (pc !== 32'h8 || alu_valid !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL ebreak_pc: pc=%h v=%b result=%h expected 8/0/0", pc, alu_valid, result);
    end
  endtask

  task automatic test_reset_mid_execute();
    goto_pc(32'h0C);
    regs[4] = 32'h1234;
    do_decode(enc_i(12'h7FF, 5'd4, 3'd0, 5'd9, 7'h13));
    execute_en = 1'b1;
    decode_en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; execute_en = 1'b0; decode_en = 1'b0;
    model_reset();
    checks++;
    if ({op1, op2, op3, rd, pc, alu_result, alu_valid, ret_addr, result} !== '0) begin
      failures++;
      $display("FAIL reset_mid_exec: pc=%h op1=%h op2=%h rd=%0d alu=%h v=%b ret=%h res=%h expected all zero",
               pc, op1, op2, rd, alu_result, alu_valid, ret_addr, result);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: begin r[6:0] = 7'h33; r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h37;
      3: r[6:0] = 7'h17;
      4: r[6:0] = 7'h6F;
      5: r[6:0] = 7'h67;
      6: r[6:0] = 7'h63;
      7: r[6:0] = 7'h03;
      8: r[6:0] = 7'h23;
      9: r[6:0] = 7'h73;
      10: r = EBRK;
      default: r[6:0] = 7'h0B;
    endcase
    return r;
  endfunction

  task automatic rand_regs(input logic [31:0] i);
    for (int k = 1; k < 32; k++) regs[k] = $urandom;
    if ($urandom_range(0, 2) == 0 && i[24:20] != 5'd0) regs[i[24:20]] = rf(i[19:15]);
  endtask

  task automatic test_random();
    logic [31:0] i;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      i = rand_instr();
      rand_regs(i);
      do_decode(i);
      do_execute();
      checks++;
      if ({op1, op2, op3, rd, pc, alu_result, alu_valid, ret_addr, result} !==
          {m_op1, m_op2, m_op3, m_rd, m_pc, m_alu, m_valid, m_ret, m_result}) begin
        failures++;
        $display("FAIL rand_exec[%0d] instr=%h got pc=%h alu=%h v=%b ret=%h res=%h ops=%h/%h/%h rd=%0d want pc=%h alu=%h v=%b ret=%h res=%h ops=%h/%h/%h rd=%0d",
                 n, i, pc, alu_result, alu_valid, ret_addr, result, op1, op2, op3, rd,
                 m_pc, m_alu, m_valid, m_ret, m_result, m_op1, m_op2, m_op3, m_rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, p;
    do_reset();
    for (int n = 0; n < 100; n++) begin
      a = rand_instr();
      b = rand_instr();
      rand_regs(a);
      do_decode(a);
      rand_regs(b);
      instr = b;
      decode_en = 1'b1;
      execute_en = 1'b1;
      p = m_pc;
      model_execute();
      model_decode(b, p);
      tick();
      decode_en = 1'b0;
      execute_en = 1'b0;
      checks++;
      if ({op1, op2, op3, rd, pc, alu_result, alu_valid, ret_addr, result} !==
          {m_op1, m_op2, m_op3, m_rd, m_pc, m_alu, m_valid, m_ret, m_result}) begin
        failures++;
        $display("FAIL b2b[%0d] a=%h b=%h got pc=%h alu=%h v=%b ret=%h res=%h ops=%h/%h/%h rd=%0d want pc=%h alu=%h v=%b ret=%h res=%h ops=%h/%h/%h rd=%0d",
                 n, a, b, pc, alu_result, alu_valid, ret_addr, result, op1, op2, op3, rd,
                 m_pc, m_alu, m_valid, m_ret, m_result, m_op1, m_op2, m_op3, m_rd);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    decode_en = 1'b0;
    execute_en = 1'b0;
    instr = NOP;
    for (int k = 0; k < 32; k++) regs[k] = 32'd0;
    model_reset();
    test_reset();
    test_addi();
    test_alu_edges();
    test_branch();
    test_jumps();
    test_upper();
    test_ebreak();
    test_reset_mid_execute();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
